pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Multi-cycle sequencer for the Hack CPU. It fetches each instruction through a req/ack ROM handshake and latches it into an instruction register.
- It drives the A/D register loads and the data-memory write handshake.
- It alone drives the program counter's reset/load/inc controls, including jump resolution from ALU flags.
- It also detects the canonical end-of-program idiom, a jump to self, and halts.

Parameters:
- TIMEOUT, 255, max cycles waiting for rom_ack or mem_ack before entering ERROR; 0 disables the timeout.
- HALT_DETECT, 1, when 1, a taken jump with a_val == pc_val enters HALT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level enable; sampled only on entry to FETCH
- rom_req  out  1  instruction fetch request
- rom_ack  in  1  fetch data valid this cycle; may be combinational from rom_req
- rom_data  in  16  instruction word
- ir  out  16  instruction register
- alu_zr  in  1  ALU output == 0, valid during EXEC
- alu_ng  in  1  ALU output < 0, valid during EXEC
- pc_val  in  16  current PC value
- a_val  in  16  current A register value
- a_load  out  1  load A
- d_load  out  1  load D
- mem_req  out  1  data memory write request
- mem_ack  in  1  write accepted
- pc_reset  out  1  PC reset control
- pc_load  out  1  PC load control (PC <= A)
- pc_inc  out  1  PC increment control
- halted  out  1  in HALT
- error  out  1  in ERROR (timeout)

Behaviour:
- Reset (reset=0, async) puts the FSM in BOOT. All outputs are 0 and ir=16'h0000.
- At most one of pc_reset/pc_load/pc_inc is high in any cycle. a_load/d_load are high for exactly one cycle per instruction.
- States:
  - BOOT: pc_reset=1 for exactly one cycle, then go to FETCH.
  - FETCH: if run=0 on entry, go to IDLE. Otherwise rom_req=1 until the cycle rom_ack=1. In that cycle, ir<=rom_data and the next state is EXEC.
  - IDLE: all outputs 0. When run=1, go to FETCH (rom_req asserted the next cycle).
  - EXEC (exactly 1 cycle):
    - A-inst (ir[15]=0): a_load=1 and pc_inc=1, then go to FETCH.
    - C-inst: a_load=ir[5] and d_load=ir[4].
      - take = (ir[2]&ng) | (ir[1]&zr) | (ir[0]&~ng&~zr).
      - If ir[3]=1 (dest M), go to MEM with no PC control asserted in EXEC.
      - Otherwise assert pc_load if take, else pc_inc, then go to FETCH. If take and HALT_DETECT and a_val==pc_val, go to HALT instead, with pc_load suppressed.
      - The jump decision uses a_val sampled in EXEC, i.e. before any a_load takes effect.
  - MEM: mem_req=1 until mem_ack=1.
    - In the ack cycle, assert pc_load/pc_inc using take, which was registered in EXEC.
    - The halt check is likewise registered in EXEC. If it held, go to HALT with no PC control asserted; otherwise go to FETCH.
  - HALT: halted=1, all controls 0. Exit only by reset.
  - ERROR: a wait counter in FETCH or MEM reached TIMEOUT with no ack. error=1, all controls 0, rom_req/mem_req dropped. Exit only by reset.
- Wait counter: cleared on entry to FETCH/MEM, incremented per non-ack cycle, saturating. An ack in the same cycle the counter reaches TIMEOUT wins.
- Latency with zero-wait memories: A-inst or non-M C-inst takes 2 cycles (FETCH+EXEC); an M-writing C-inst takes 3 cycles.
- Reset asserted mid-handshake: rom_req and mem_req drop asynchronously. Peers must tolerate a request withdrawn without ack.
- ir bits [14:13] are ignored. A C-inst with j=000 never jumps.

Decomposition:
- Shared defines header (guarded like other includes):
  - state encodings: BOOT, IDLE, FETCH, EXEC, MEM, HALT, ERROR (3-bit)
  - instruction field positions: INST_C=15, DEST_A=5, DEST_D=4, DEST_M=3, JLT=2, JEQ=1, JGT=0
- One combinational sub-module: jump_cond (inputs j[2:0], zr, ng; output take), reusable by a future pipelined CPU.

Test Plan:
- Reset then run=1, ROM acks immediately: pc_reset=1 in cycle 1 only; rom_req=1 in cycle 2; with rom_data=16'h0005, EXEC shows a_load=1 and pc_inc=1; ir=16'h0005.
- C-inst 16'hE302 (D;JEQ) with zr=1, ng=0: EXEC asserts pc_load=1, pc_inc=0, a_load=0. Repeat with zr=0: pc_inc=1.
- C-inst 16'hE308 (M=D) with mem_ack delayed 3 cycles: mem_req held high 4 cycles; pc_inc=1 only in the ack cycle; total 6 cycles fetch-to-fetch.
- Jump-to-self 16'hEA87 (0;JMP) with a_val=pc_val=16'h0010: halted=1 next cycle, no pc_load pulse, rom_req stays 0 for 20 cycles. Same instruction with a_val=16'h0011: pc_load=1, back to FETCH.
- TIMEOUT=4, rom_ack stuck at 0: rom_req high 4 cycles, then error=1 and rom_req=0. Then assert reset=0: BOOT, error=0.
- run=0 at FETCH entry: IDLE with no rom_req. Raise run: rom_req the following cycle. Assert reset=0 during MEM: mem_req drops the same cycle (async); state returns to BOOT.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the Hack CPU sequencer: FSM state encodings,
// instruction field positions and datapath widths.
package pc_seq_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 16;

    // Hack C-instruction field positions
    localparam int unsigned INST_C = 15;
    localparam int unsigned DEST_A = 5;
    localparam int unsigned DEST_D = 4;
    localparam int unsigned DEST_M = 3;
    localparam int unsigned JLT    = 2;
    localparam int unsigned JEQ    = 1;
    localparam int unsigned JGT    = 0;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        IDLE  = 3'd1,
        FETCH = 3'd2,
        EXEC  = 3'd3,
        MEM   = 3'd4,
        HALT  = 3'd5,
        ERROR = 3'd6
    } state_t;

endpackage

// File: rtl/pc_seq_jump_cond.sv
// Hack jump condition: resolves the j[2:0] field against the ALU zr/ng flags.
module pc_seq_jump_cond
    import pc_seq_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    assign take = (j[JLT] & ng) | (j[JEQ] & zr) | (j[JGT] & ~ng & ~zr);

endmodule

// File: rtl/pc_seq.sv
// Multi-cycle Hack CPU sequencer: instruction fetch, A/D/M write control,
// program counter control with jump resolution, halt-on-jump-to-self and timeouts.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 255,
    parameter bit          HALT_DETECT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [WORD_W-1:0] rom_data,
    output logic [WORD_W-1:0] ir,
    input  logic              alu_zr,
    input  logic              alu_ng,
    input  logic [WORD_W-1:0] pc_val,
    input  logic [WORD_W-1:0] a_val,
    output logic              a_load,
    output logic              d_load,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_reset,
    output logic              pc_load,
    output logic              pc_inc,
    output logic              halted,
    output logic              error
);

    state_t             state_q;
    state_t             state_d;
    logic [WORD_W-1:0]  ir_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               take_q;
    logic               halt_q;
    logic               take_c;
    logic               halt_c;
    logic               timeout_c;
    logic               waiting_c;
    state_t             after_c;

    pc_seq_jump_cond u_jump_cond (
        .j    (ir_q[JLT:JGT]),
        .zr   (alu_zr),
        .ng   (alu_ng),
        .take (take_c)
    );

    // Jump-to-self check uses a_val as seen in EXEC, before any A load lands
    assign halt_c    = take_c & HALT_DETECT & (a_val == pc_val);
    assign timeout_c = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign waiting_c = ((state_q == FETCH) && !rom_ack) || ((state_q == MEM) && !mem_ack);
    assign after_c   = run ? FETCH : IDLE;
    assign ir        = ir_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control decode; handshake acks feed straight through to PC controls
    always_comb begin
        state_d  = state_q;
        rom_req  = 1'b0;
        mem_req  = 1'b0;
        a_load   = 1'b0;
        d_load   = 1'b0;
        pc_reset = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        halted   = 1'b0;
        error    = 1'b0;
        case (state_q)
            BOOT: begin
                pc_reset = reset;
                state_d  = after_c;
            end
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rom_req = 1'b1;
                if (rom_ack) begin
                    state_d = EXEC;
                end else if (timeout_c) begin
                    state_d = ERROR;
                end
            end
            EXEC: begin
                if (!ir_q[INST_C]) begin
                    a_load  = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = after_c;
                end else begin
                    a_load = ir_q[DEST_A];
                    d_load = ir_q[DEST_D];
                    if (ir_q[DEST_M]) begin
                        state_d = MEM;
                    end else if (halt_c) begin
                        state_d = HALT;
                    end else begin
                        pc_load = take_c;
                        pc_inc  = ~take_c;
                        state_d = after_c;
                    end
                end
            end
            MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (halt_q) begin
                        state_d = HALT;
                    end else begin
                        pc_load = take_q;
                        pc_inc  = ~take_q;
                        state_d = after_c;
                    end
                end else if (timeout_c) begin
                    state_d = ERROR;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q <= '0;
        end else if ((state_q == FETCH) && rom_ack) begin
            ir_q <= rom_data;
        end
    end

    // Jump decision for M-writing instructions is frozen in EXEC for use in MEM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            take_q <= 1'b0;
            halt_q <= 1'b0;
        end else if (state_q == EXEC) begin
            take_q <= take_c;
            halt_q <= halt_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((state_d != state_q) && ((state_d == FETCH) || (state_d == MEM))) begin
            wait_cnt <= '0;
        end else if (waiting_c && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: an ISA-level model predicts every cycle's controls,
// checked at the falling edge, plus hand-computed literal expectations.
module tb_pc_seq;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        reset;
    logic        run;
    logic        rom_req;
    logic        rom_ack;
    logic        rom_rdy;
    logic [15:0] rom_data;
    logic [15:0] ir;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] pc_val;
    logic [15:0] a_val;
    logic        a_load;
    logic        d_load;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_rdy;
    logic        pc_reset;
    logic        pc_load;
    logic        pc_inc;
    logic        halted;
    logic        error;

    typedef struct packed {
        logic        rom_req;
        logic        mem_req;
        logic        a_load;
        logic        d_load;
        logic        pc_reset;
        logic        pc_load;
        logic        pc_inc;
        logic        halted;
        logic        error;
        logic [15:0] ir;
    } obs_t;

    typedef struct packed {
        logic a_ld;
        logic d_ld;
        logic to_mem;
        logic take;
        logic self;
    } dec_t;

    obs_t        exp_o;
    obs_t        last;
    bit          chk;
    string       tag;
    int          tests;
    int          fails;
    logic [15:0] cur_ir;

    assign rom_ack = rom_req & rom_rdy;
    assign mem_ack = mem_req & mem_rdy;

    pc_seq #(.TIMEOUT(TO), .HALT_DETECT(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .rom_req  (rom_req),
        .rom_ack  (rom_ack),
        .rom_data (rom_data),
        .ir       (ir),
        .alu_zr   (alu_zr),
        .alu_ng   (alu_ng),
        .pc_val   (pc_val),
        .a_val    (a_val),
        .a_load   (a_load),
        .d_load   (d_load),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .pc_reset (pc_reset),
        .pc_load  (pc_load),
        .pc_inc   (pc_inc),
        .halted   (halted),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle compare against the model's expectation
    always @(negedge clk) begin
        last = '{rom_req, mem_req, a_load, d_load, pc_reset, pc_load, pc_inc, halted, error, ir};
        if (chk) begin
            tests++;
            if (last !== exp_o) begin
                fails++;
                $display("FAIL %s @%0t: got ctl=%b ir=%h, want ctl=%b ir=%h", tag, $time,
                         last[24:16], last.ir, exp_o[24:16], exp_o.ir);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    function automatic obs_t o(input logic [15:0] i);
        obs_t r;
        r    = '0;
        r.ir = i;
        return r;
    endfunction

    // Hack ISA semantics for one instruction, by jump mnemonic
    function automatic dec_t isa(input logic [15:0] i, input logic zr, input logic ng,
                                 input logic [15:0] a, input logic [15:0] pc);
        dec_t d;
        logic lt, eq, gt;
        d = '0;
        if (!i[15]) begin
            d.a_ld = 1'b1;
            return d;
        end
        lt = ng;
        eq = zr;
        gt = !ng && !zr;
        case (i[2:0])
            3'b000:  d.take = 1'b0;
            3'b001:  d.take = gt;
            3'b010:  d.take = eq;
            3'b011:  d.take = gt || eq;
            3'b100:  d.take = lt;
            3'b101:  d.take = lt || gt;
            3'b110:  d.take = lt || eq;
            default: d.take = 1'b1;
        endcase
        d.a_ld   = i[5];
        d.d_ld   = i[4];
        d.to_mem = i[3];
        d.self   = d.take && (a == pc);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input obs_t e);
        exp_o = e;
        chk   = 1'b1;
        tick();
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // One instruction from FETCH entry; status 0 = next fetch/idle, 1 = halt, 2 = timeout
    task automatic run_inst(input string name, input logic [15:0] instr, input int fw,
                            input int mw, input logic zr, input logic ng,
                            input logic [15:0] a, input logic [15:0] pc,
                            output int status, output int cycles);
        dec_t d;
        obs_t e;
        status = 0;
        cycles = 0;
        tag    = name;
        for (int w = 0; w <= fw; w++) begin
            if (w == int'(TO)) begin
                rom_rdy = 1'b0;
                status  = 2;
                return;
            end
            rom_rdy   = (w == fw);
            rom_data  = (w == fw) ? instr : 16'hFFFF;
            e         = o(cur_ir);
            e.rom_req = 1'b1;
            cyc(e);
            cycles++;
        end
        rom_rdy = 1'b0;
        cur_ir  = instr;
        alu_zr  = zr;
        alu_ng  = ng;
        a_val   = a;
        pc_val  = pc;
        d       = isa(instr, zr, ng, a, pc);
        e        = o(cur_ir);
        e.a_load = d.a_ld;
        e.d_load = d.d_ld;
        if (!d.to_mem && !d.self) begin
            e.pc_load = d.take;
            e.pc_inc  = !d.take;
        end
        cyc(e);
        cycles++;
        if (d.to_mem) begin
            alu_zr = ng;
            alu_ng = zr;
            a_val  = a + 16'h0001;
            for (int w = 0; w <= mw; w++) begin
                if (w == int'(TO)) begin
                    mem_rdy = 1'b0;
                    status  = 2;
                    return;
                end
                mem_rdy   = (w == mw);
                e         = o(cur_ir);
                e.mem_req = 1'b1;
                if ((w == mw) && !d.self) begin
                    e.pc_load = d.take;
                    e.pc_inc  = !d.take;
                end
                cyc(e);
                cycles++;
            end
            mem_rdy = 1'b0;
        end
        status = d.self ? 1 : 0;
    endtask

    task automatic hold(input string name, input int n, input bit is_halt, output int req_seen);
        obs_t e;
        tag      = name;
        req_seen = 0;
        for (int k = 0; k < n; k++) begin
            e        = o(cur_ir);
            e.halted = is_halt;
            e.error  = !is_halt;
            cyc(e);
            req_seen += int'(last.rom_req | last.mem_req);
        end
    endtask

    task automatic do_reset(input logic run_v);
        obs_t e;
        reset   = 1'b0;
        run     = run_v;
        rom_rdy = 1'b0;
        mem_rdy = 1'b0;
        cur_ir  = 16'h0000;
        tag     = "reset";
        cyc(o(16'h0000));
        reset      = 1'b1;
        e          = o(16'h0000);
        e.pc_reset = 1'b1;
        tag        = "boot";
        cyc(e);
    endtask

    initial begin
        obs_t e;
        int   st;
        int   n;
        int   seen;
        tests    = 0;
        fails    = 0;
        chk      = 1'b0;
        tag      = "reset";
        reset    = 1'b1;
        run      = 1'b1;
        rom_rdy  = 1'b0;
        mem_rdy  = 1'b0;
        rom_data = 16'h0000;
        alu_zr   = 1'b0;
        alu_ng   = 1'b0;
        pc_val   = 16'h0000;
        a_val    = 16'h0000;
        cur_ir   = 16'h0000;
        #1 reset = 1'b0;
        tick();

        cyc(o(16'h0000));
        lit("reset_ir", 32'(ir), 32'h0000);
        reset      = 1'b1;
        e          = o(16'h0000);
        e.pc_reset = 1'b1;
        tag        = "boot";
        cyc(e);
        lit("boot_pc_reset", 32'(last.pc_reset), 1);

        run_inst("a_inst", 16'h0005, 0, 0, 1'b0, 1'b0, 16'h0100, 16'h0000, st, n);
        lit("a_inst_ir", 32'(last.ir), 32'h0005);
        lit("a_inst_ctl", 32'({last.a_load, last.pc_inc, last.pc_load}), 32'b110);
        lit("a_inst_cycles", 32'(n), 2);

        run_inst("jeq_taken", 16'hE302, 0, 0, 1'b1, 1'b0, 16'h0100, 16'h0001, st, n);
        lit("jeq_taken_ctl", 32'({last.pc_load, last.pc_inc, last.a_load}), 32'b100);
        run_inst("jeq_not", 16'hE302, 0, 0, 1'b0, 1'b0, 16'h0100, 16'h0002, st, n);
        lit("jeq_not_inc", 32'({last.pc_load, last.pc_inc}), 32'b01);
        run_inst("jeq_neg", 16'hE302, 1, 0, 1'b0, 1'b1, 16'h0100, 16'h0003, st, n);
        run_inst("jge_ad", 16'h8333, 2, 0, 1'b0, 1'b0, 16'h0100, 16'h0004, st, n);
        lit("jge_ad_ctl", 32'({last.a_load, last.d_load, last.pc_load}), 32'b111);
        run_inst("jlt", 16'hE304, 0, 0, 1'b0, 1'b1, 16'h0100, 16'h0005, st, n);
        run_inst("m_jne", 16'hE31D, 0, 0, 1'b0, 1'b0, 16'h0100, 16'h0006, st, n);
        lit("m_jne_cycles", 32'(n), 3);
        lit("m_jne_load", 32'(last.pc_load), 1);
        run_inst("m_wait3", 16'hE308, 0, 3, 1'b0, 1'b0, 16'h0100, 16'h0007, st, n);
        lit("m_wait3_cycles", 32'(n), 6);
        lit("m_wait3_inc", 32'({last.mem_req, last.pc_inc}), 32'b11);
        run_inst("rom_wait3", 16'h0007, 3, 0, 1'b0, 1'b0, 16'h0100, 16'h0008, st, n);
        lit("rom_wait3_cycles", 32'(n), 5);

        run_inst("self_jmp", 16'hEA87, 0, 0, 1'b0, 1'b0, 16'h0010, 16'h0010, st, n);
        lit("self_jmp_status", 32'(st), 1);
        lit("self_jmp_noload", 32'(last.pc_load), 0);
        hold("halt_hold", 20, 1'b1, seen);
        lit("halt_no_req", 32'(seen), 0);
        lit("halt_flag", 32'(last.halted), 1);

        do_reset(1'b1);
        run_inst("jmp_other", 16'hEA87, 0, 0, 1'b0, 1'b0, 16'h0011, 16'h0010, st, n);
        lit("jmp_other_load", 32'({last.pc_load, last.halted}), 32'b10);
        run_inst("m_self", 16'hEA8F, 0, 1, 1'b0, 1'b0, 16'h0020, 16'h0020, st, n);
        lit("m_self_status", 32'(st), 1);
        hold("m_halt_hold", 3, 1'b1, seen);

        do_reset(1'b1);
        run_inst("rom_timeout", 16'h0001, 6, 0, 1'b0, 1'b0, 16'h0100, 16'h0000, st, n);
        lit("rom_timeout_status", 32'(st), 2);
        lit("rom_timeout_reqs", 32'(n), 4);
        hold("error_hold", 3, 1'b0, seen);
        lit("error_no_req", 32'(seen), 0);
        lit("error_flag", 32'(last.error), 1);
        do_reset(1'b1);
        lit("error_cleared", 32'(last.error), 0);
        run_inst("mem_timeout", 16'hE308, 0, 10, 1'b0, 1'b0, 16'h0100, 16'h0000, st, n);
        lit("mem_timeout_status", 32'(st), 2);
        hold("mem_error_hold", 2, 1'b0, seen);

        do_reset(1'b0);
        tag = "idle";
        for (int k = 0; k < 3; k++) cyc(o(16'h0000));
        lit("idle_no_req", 32'(last.rom_req), 0);
        run = 1'b1;
        cyc(o(16'h0000));
        run_inst("after_idle", 16'h0003, 0, 0, 1'b0, 1'b0, 16'h0100, 16'h0000, st, n);
        lit("after_idle_cycles", 32'(n), 2);
        run = 1'b0;
        run_inst("to_idle", 16'h0004, 0, 0, 1'b0, 1'b0, 16'h0100, 16'h0001, st, n);
        tag = "idle2";
        cyc(o(cur_ir));
        cyc(o(cur_ir));
        run = 1'b1;
        cyc(o(cur_ir));

        tag       = "mem_reset";
        rom_rdy   = 1'b1;
        rom_data  = 16'hE308;
        a_val     = 16'h0100;
        pc_val    = 16'h0004;
        e         = o(cur_ir);
        e.rom_req = 1'b1;
        cyc(e);
        rom_rdy = 1'b0;
        cur_ir  = 16'hE308;
        cyc(o(cur_ir));
        e         = o(cur_ir);
        e.mem_req = 1'b1;
        cyc(e);
        #1;
        lit("mem_req_pre_reset", 32'(mem_req), 1);
        #1 reset = 1'b0;
        #1;
        lit("mem_req_async_drop", 32'(mem_req), 0);
        cur_ir = 16'h0000;
        cyc(o(16'h0000));
        reset      = 1'b1;
        e          = o(16'h0000);
        e.pc_reset = 1'b1;
        tag        = "mem_reset_boot";
        cyc(e);
        lit("mem_reset_boot", 32'(last.pc_reset), 1);
        run_inst("resume", 16'h0002, 0, 0, 1'b0, 1'b0, 16'h0100, 16'h0000, st, n);
        lit("resume_ir", 32'(last.ir), 32'h0002);

        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
